spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank_if.sv | 21 ++
 rtl/spi_reg_bank.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// Register-bus handshake between spi_reg_bank (master) and the hard-SPI
// register bridge (slave).
interface spi_reg_bank_if;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] address;
    logic [7:0] wb_write_data;
    logic [7:0] wb_read_data;
    logic       wb_xfer_rdy;
    logic       wb_xfer_done;

    modport master (
        output rd_en, wr_en, address, wb_write_data,
        input  wb_read_data, wb_xfer_rdy, wb_xfer_done
    );

    modport slave (
        input  rd_en, wr_en, address, wb_write_data,
        output wb_read_data, wb_xfer_rdy, wb_xfer_done
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-addressable register bank driving a hard-SPI core over its register bus.
// Optional macro SPI_REG_WR_STROBE_EN adds reg_wr_strobe (per-register write pulse).
module spi_reg_bank #(
    parameter int                    NUM_REGS     = 8,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = {{((NUM_REGS - 1) * 8){1'b0}}, 8'hFF},
    parameter logic [NUM_REGS-1:0]   WR_MASK      = {NUM_REGS{1'b1}},
    parameter int                    TIMEOUT      = 255,
    parameter logic [7:0]            SPITXDR      = 8'h59,
    parameter logic [7:0]            SPIISR       = 8'h5A,
    parameter logic [7:0]            SPIRXDR      = 8'h5B
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  spi_csn,
    spi_reg_bank_if.master        bus,
    input  logic [NUM_REGS*8-1:0] ro_in,
    output logic [NUM_REGS*8-1:0] regs_out,
`ifdef SPI_REG_WR_STROBE_EN
    output logic [NUM_REGS-1:0]   reg_wr_strobe,
`endif
    output logic                  txn_err
);

    localparam int PW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW       = $clog2(TIMEOUT + 2);
    localparam int ISR_RRDY = 3;
    localparam int ISR_TRDY = 4;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH_RX,
        PRIME_TX,
        POLL_CMD,
        LOAD_CMD,
        POLL_DATA,
        TX_DATA,
        RX_DATA
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cs_sync_reg;
    logic            start_reg, start_next;
    logic            end_pend_reg, end_pend_next;
    logic            rd_en_reg, rd_en_next;
    logic            wr_en_reg, wr_en_next;
    logic [7:0]      addr_reg, addr_next;
    logic [7:0]      wdata_reg, wdata_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic            is_write_reg, is_write_next;
    logic            load_phase_reg, load_phase_next;
    logic [TW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic            txn_err_reg, txn_err_next;

    logic            cs_fall;
    logic            cs_rise;
    logic            end_now;
    logic            reg_we;
    logic [PW-1:0]   cmd_ptr;
    logic [PW-1:0]   ptr_inc;
    logic [7:0]      cmd_ptr_val;
    logic [7:0]      ptr_inc_val;

    // Per-access launch request computed inside the done handler
    state_t          after_state;
    logic            launch_rd;
    logic            launch_wr;
    logic [7:0]      launch_addr;
    logic [7:0]      launch_data;

    // Chip-select synchroniser: bits [1:0] resolve metastability, bit 2 is the previous sample
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cs_sync_reg <= 3'b111;
        end else begin
            cs_sync_reg <= {cs_sync_reg[1:0], spi_csn};
        end
    end

    assign cs_fall = cs_sync_reg[2] & ~cs_sync_reg[1];
    assign cs_rise = ~cs_sync_reg[2] & cs_sync_reg[1];

    assign cmd_ptr     = bus.wb_read_data[PW-1:0];
    assign ptr_inc     = ptr_reg + PW'(1);
    assign cmd_ptr_val = regs_out[{cmd_ptr, 3'b000} +: 8];
    assign ptr_inc_val = regs_out[{ptr_inc, 3'b000} +: 8];

    // Register storage and read-back mux; read-only slots reflect ro_in directly
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] value_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    value_reg <= RESET_VALUES[gi*8 +: 8];
                end else if (reg_we && (ptr_reg == PW'(gi))) begin
                    value_reg <= bus.wb_read_data;
                end
            end

            assign regs_out[gi*8 +: 8] = WR_MASK[gi] ? value_reg : ro_in[gi*8 +: 8];

`ifdef SPI_REG_WR_STROBE_EN
            logic strobe_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    strobe_reg <= 1'b0;
                end else begin
                    strobe_reg <= reg_we && (ptr_reg == PW'(gi));
                end
            end

            assign reg_wr_strobe[gi] = strobe_reg;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            start_reg      <= 1'b0;
            end_pend_reg   <= 1'b0;
            rd_en_reg      <= 1'b0;
            wr_en_reg      <= 1'b0;
            addr_reg       <= SPITXDR;
            wdata_reg      <= 8'h00;
            ptr_reg        <= '0;
            is_write_reg   <= 1'b0;
            load_phase_reg <= 1'b0;
            wait_cnt_reg   <= '0;
            txn_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_reg      <= start_next;
            end_pend_reg   <= end_pend_next;
            rd_en_reg      <= rd_en_next;
            wr_en_reg      <= wr_en_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            ptr_reg        <= ptr_next;
            is_write_reg   <= is_write_next;
            load_phase_reg <= load_phase_next;
            wait_cnt_reg   <= wait_cnt_next;
            txn_err_reg    <= txn_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        start_next      = start_reg | cs_fall;
        end_pend_next   = end_pend_reg;
        rd_en_next      = 1'b0;
        wr_en_next      = 1'b0;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        ptr_next        = ptr_reg;
        is_write_next   = is_write_reg;
        load_phase_next = load_phase_reg;
        wait_cnt_next   = wait_cnt_reg;
        txn_err_next    = txn_err_reg;
        reg_we          = 1'b0;
        end_now         = end_pend_reg | cs_rise;
        after_state     = state_reg;
        launch_rd       = 1'b0;
        launch_wr       = 1'b0;
        launch_addr     = addr_reg;
        launch_data     = wdata_reg;

        if (state_reg == IDLE) begin
            end_pend_next = 1'b0;
            if (start_reg && bus.wb_xfer_rdy) begin
                // A falling edge landing in this very cycle stays latched
                start_next    = cs_fall;
                state_next    = FLUSH_RX;
                rd_en_next    = 1'b1;
                addr_next     = SPIRXDR;
                wait_cnt_next = '0;
            end
        end else begin
            end_pend_next = end_now;
            if (bus.wb_xfer_done) begin
                case (state_reg)
                    FLUSH_RX: begin
                        after_state = PRIME_TX;
                        launch_wr   = 1'b1;
                        launch_addr = SPITXDR;
                        launch_data = 8'h00;
                    end
                    PRIME_TX: begin
                        after_state = POLL_CMD;
                        launch_rd   = 1'b1;
                        launch_addr = SPIISR;
                    end
                    POLL_CMD: begin
                        if (bus.wb_read_data[ISR_RRDY]) begin
                            after_state     = LOAD_CMD;
                            launch_rd       = 1'b1;
                            launch_addr     = SPIRXDR;
                            load_phase_next = 1'b0;
                        end else if (bus.wb_read_data[ISR_TRDY]) begin
                            after_state = PRIME_TX;
                            launch_wr   = 1'b1;
                            launch_addr = SPITXDR;
                            launch_data = 8'h00;
                        end else begin
                            after_state = POLL_CMD;
                            launch_rd   = 1'b1;
                            launch_addr = SPIISR;
                        end
                    end
                    LOAD_CMD: begin
                        // Two accesses: fetch the command, then queue the first MISO byte
                        if (!load_phase_reg) begin
                            is_write_next   = bus.wb_read_data[7];
                            ptr_next        = cmd_ptr;
                            load_phase_next = 1'b1;
                            after_state     = LOAD_CMD;
                            launch_wr       = 1'b1;
                            launch_addr     = SPITXDR;
                            launch_data     = cmd_ptr_val;
                        end else begin
                            load_phase_next = 1'b0;
                            after_state     = POLL_DATA;
                            launch_rd       = 1'b1;
                            launch_addr     = SPIISR;
                        end
                    end
                    POLL_DATA: begin
                        if (bus.wb_read_data[ISR_RRDY]) begin
                            after_state = RX_DATA;
                            launch_rd   = 1'b1;
                            launch_addr = SPIRXDR;
                        end else if (bus.wb_read_data[ISR_TRDY]) begin
                            after_state = TX_DATA;
                            launch_wr   = 1'b1;
                            launch_addr = SPITXDR;
                            if (is_write_reg) begin
                                launch_data = 8'h00;
                            end else begin
                                launch_data = ptr_inc_val;
                                ptr_next    = ptr_inc;
                            end
                        end else begin
                            after_state = POLL_DATA;
                            launch_rd   = 1'b1;
                            launch_addr = SPIISR;
                        end
                    end
                    TX_DATA: begin
                        after_state = POLL_DATA;
                        launch_rd   = 1'b1;
                        launch_addr = SPIISR;
                    end
                    RX_DATA: begin
                        // The received byte is committed even when the frame is ending
                        if (is_write_reg) begin
                            reg_we   = WR_MASK[ptr_reg];
                            ptr_next = ptr_inc;
                        end
                        after_state = POLL_DATA;
                        launch_rd   = 1'b1;
                        launch_addr = SPIISR;
                    end
                    default: begin
                        after_state = IDLE;
                    end
                endcase

                wait_cnt_next = '0;
                if (end_now) begin
                    state_next      = IDLE;
                    load_phase_next = 1'b0;
                end else begin
                    state_next = after_state;
                    rd_en_next = launch_rd;
                    wr_en_next = launch_wr;
                    addr_next  = launch_addr;
                    wdata_next = launch_data;
                end
            end else if (wait_cnt_reg == TW'(TIMEOUT)) begin
                txn_err_next    = 1'b1;
                state_next      = IDLE;
                load_phase_next = 1'b0;
                wait_cnt_next   = '0;
            end else begin
                wait_cnt_next = wait_cnt_reg + TW'(1);
            end
        end
    end

    assign bus.rd_en         = rd_en_reg;
    assign bus.wr_en         = wr_en_reg;
    assign bus.address       = addr_reg;
    assign bus.wb_write_data = wdata_reg;
    assign txn_err           = txn_err_reg;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a reactive hard-SPI register model on the bus.
module tb_spi_reg_bank;

    localparam int         NR   = 8;
    localparam logic [7:0] TXDR = 8'h59;
    localparam logic [7:0] ISR  = 8'h5A;
    localparam logic [7:0] RXDR = 8'h5B;

    logic            clk     = 1'b0;
    logic            rstn    = 1'b0;
    logic            spi_csn = 1'b1;
    logic [NR*8-1:0] ro_in   = '0;
    logic [NR*8-1:0] regs_out;
    logic            txn_err;
`ifdef SPI_REG_WR_STROBE_EN
    logic [NR-1:0]   reg_wr_strobe;
`endif

    spi_reg_bank_if bus();

    spi_reg_bank #(
        .NUM_REGS (NR),
        .WR_MASK  (8'hFD)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .spi_csn       (spi_csn),
        .bus           (bus),
        .ro_in         (ro_in),
        .regs_out      (regs_out),
`ifdef SPI_REG_WR_STROBE_EN
        .reg_wr_strobe (reg_wr_strobe),
`endif
        .txn_err       (txn_err)
    );

    always #5 clk = ~clk;

    // Hard-SPI register model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         strobe_cnt  = 0;
    int         proto_err   = 0;
    int         lat         = 2;
    bit         hold_done   = 1'b0;
    bit         trdy_en     = 1'b0;
    bit         pending     = 1'b0;
    bit         pend_wr     = 1'b0;
    bit         prev_strobe = 1'b0;
    int         pend_cnt    = 0;
    logic [7:0] pend_addr   = 8'h00;
    logic [7:0] pend_data   = 8'h00;
    logic [7:0] rdata       = 8'h00;

    int checks = 0;
    int errors = 0;

    assign bus.wb_xfer_rdy = 1'b1;

    always @(negedge clk) begin
        bus.wb_xfer_done = 1'b0;
        if (!rstn) begin
            pending     = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (bus.rd_en && bus.wr_en) proto_err++;
            if ((bus.rd_en || bus.wr_en) && prev_strobe) proto_err++;
            prev_strobe = bus.rd_en || bus.wr_en;
            if (pending) begin
                if (bus.address !== pend_addr) proto_err++;
                if (pend_wr && (bus.wb_write_data !== pend_data)) proto_err++;
                if (pend_cnt <= 1) begin
                    pending          = 1'b0;
                    bus.wb_xfer_done = 1'b1;
                    bus.wb_read_data = rdata;
                end else begin
                    pend_cnt--;
                end
            end
            if (bus.rd_en || bus.wr_en) begin
                strobe_cnt++;
                if (pending) proto_err++;
                rdata = 8'h00;
                if (bus.wr_en) begin
                    if (bus.address == TXDR) tx_log.push_back(bus.wb_write_data);
                    else proto_err++;
                end else if (bus.address == RXDR) begin
                    if (rx_q.size() > 0) rdata = rx_q.pop_front();
                end else if (bus.address == ISR) begin
                    rdata = {3'b000, trdy_en, (rx_q.size() > 0), 3'b000};
                end else begin
                    proto_err++;
                end
                pending   = !hold_done;
                pend_cnt  = lat;
                pend_wr   = bus.wr_en;
                pend_addr = bus.address;
                pend_data = bus.wb_write_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs one SPI frame: CS low until all MOSI bytes are consumed and min_tx
    // MISO bytes were queued, then CS high and confirm the bus goes quiet.
    task automatic frame(input int min_tx);
        int n;
        tx_log.delete();
        spi_csn = 1'b0;
        n = 0;
        while ((rx_q.size() != 0 || tx_log.size() < min_tx) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_progress", 64'(n < 3000), 64'd1);
        cycles(12);
        spi_csn = 1'b1;
        cycles(40);
        n = strobe_cnt;
        cycles(30);
        chk("frame_idle_strobes", 64'(strobe_cnt - n), 64'd0);
        $display("frame done: tx_bytes=%0d regs_out=%h", tx_log.size(), regs_out);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;

        // Reset state
        rstn = 1'b0;
        cycles(4);
        chk("rst_regs_out", regs_out, 64'h0000_0000_0000_00FF);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_address", 64'(bus.address), 64'h59);
        chk("rst_wdata", 64'(bus.wb_write_data), 64'h00);
        chk("rst_txn_err", 64'(txn_err), 64'd0);
        rstn = 1'b1;
        cycles(8);
        chk("idle_no_strobes", 64'(strobe_cnt), 64'd0);

        // Write 0x82: A5 -> reg2, 3C -> reg3 (leading stale byte must be flushed)
        trdy_en = 1'b0;
        rx_q = '{8'hC5, 8'h82, 8'hA5, 8'h3C};
        frame(2);
        chk("wr82_regs", regs_out, 64'h0000_0000_3CA5_00FF);
        chk("wr82_prime_tx", 64'(tx_log[0]), 64'h00);

        // Write 0x87 with TRDY also set: RRDY must win, pointer wraps 7 -> 0
        trdy_en = 1'b1;
        rx_q = '{8'hC5, 8'h87, 8'h11, 8'h22};
        frame(4);
        chk("wr87_wrap_regs", regs_out, 64'h1100_0000_3CA5_0022);
        chk("wr87_tx_fill", 64'(tx_log[3]), 64'h00);

        // Read-only slot 1 mirrors ro_in
        ro_in = 64'h0000_0000_0000_5E00;
        cycles(1);
        chk("ro_mirror", regs_out, 64'h1100_0000_3CA5_5E22);

        // Write 0x81: byte for reg1 discarded, pointer still advances to reg2
        trdy_en = 1'b0;
        rx_q = '{8'hC5, 8'h81, 8'h00, 8'h77};
        frame(2);
        chk("wr81_masked_regs", regs_out, 64'h1100_0000_3C77_5E22);
        chk("wr81_first_miso", 64'(tx_log[1]), 64'h5E);

        // Read 0x01: MISO 5E, then reg2, reg3
        trdy_en = 1'b1;
        rx_q = '{8'hC5, 8'h01};
        frame(4);
        chk("rd01_miso0", 64'(tx_log[1]), 64'h5E);
        chk("rd01_miso1", 64'(tx_log[2]), 64'h77);
        chk("rd01_miso2", 64'(tx_log[3]), 64'h3C);
        chk("rd01_regs_unchanged", regs_out, 64'h1100_0000_3C77_5E22);

        // Read 0x07: reg7 then wraps to reg0
        rx_q = '{8'hC5, 8'h07};
        frame(3);
        chk("rd07_miso0", 64'(tx_log[1]), 64'h11);
        chk("rd07_miso1", 64'(tx_log[2]), 64'h22);

        // CS rises while the data-byte RX read is in flight
        trdy_en = 1'b0;
        lat = 2;
        rx_q = '{8'hC5, 8'h84, 8'h66};
        tx_log.delete();
        spi_csn = 1'b0;
        k = 0;
        while (rx_q.size() > 1 && k < 2000) begin @(negedge clk); k++; end
        chk("end_wait_cmd", 64'(k < 2000), 64'd1);
        lat = 40;
        k = 0;
        while (rx_q.size() > 0 && k < 2000) begin @(negedge clk); k++; end
        chk("end_wait_data", 64'(k < 2000), 64'd1);
        spi_csn = 1'b1;
        n = strobe_cnt;
        cycles(100);
        chk("end_no_more_strobes", 64'(strobe_cnt - n), 64'd0);
        chk("end_byte_stored", regs_out, 64'h1100_0066_3C77_5E22);
        chk("protocol_mid", 64'(proto_err), 64'd0);
        $display("end-edge frame: strobes after cs rise=%0d", strobe_cnt - n);
        lat = 2;

        // Bus timeout: withhold wb_xfer_done on the first access
        hold_done = 1'b1;
        rx_q.delete();
        n = strobe_cnt;
        spi_csn = 1'b0;
        k = 0;
        while (strobe_cnt == n && k < 200) begin @(negedge clk); k++; end
        chk("tmo_first_access", 64'(strobe_cnt - n), 64'd1);
        cycles(250);
        chk("tmo_not_yet", 64'(txn_err), 64'd0);
        cycles(15);
        chk("tmo_txn_err", 64'(txn_err), 64'd1);
        cycles(20);
        chk("tmo_idle_no_strobes", 64'(strobe_cnt - n), 64'd1);
        hold_done = 1'b0;
        spi_csn = 1'b1;
        cycles(10);
        chk("tmo_sticky", 64'(txn_err), 64'd1);
        $display("timeout: txn_err=%0d", txn_err);

        // Reset during a slow access aborts without further strobes
        lat = 40;
        n = strobe_cnt;
        spi_csn = 1'b0;
        k = 0;
        while (strobe_cnt == n && k < 200) begin @(negedge clk); k++; end
        chk("abort_first_access", 64'(strobe_cnt - n), 64'd1);
        cycles(5);
        rstn = 1'b0;
        spi_csn = 1'b1;
        cycles(3);
        chk("abort_txn_err_clr", 64'(txn_err), 64'd0);
        chk("abort_regs_reset", regs_out, 64'h0000_0000_0000_5EFF);
        chk("abort_address", 64'(bus.address), 64'h59);
        rstn = 1'b1;
        n = strobe_cnt;
        cycles(60);
        chk("abort_no_strobes", 64'(strobe_cnt - n), 64'd0);
        chk("protocol_end", 64'(proto_err), 64'd0);
        $display("reset abort: strobes after reset=%0d", strobe_cnt - n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
